// File: rtl/sram_like_arbiter.sv
// Shares one sram-like master port between fetch and data requesters.
// Data wins by default, fetch is forced after STARVE_LIMIT data grants; returns follow an in-order owner FIFO.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err,
  output logic        o_dbg_state
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  // Handshake: a request transfers on the cycle mem_req & mem_addr_ok are both high;
  // a return transfers on mem_data_ok and belongs to the oldest accepted request.
  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [MAX_OUTSTANDING-1:0] r_own_q;
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [CW-1:0]              r_count;
  logic [SW-1:0]              r_starve;
  logic                       r_perr;
  logic                       r_lk_own;
  logic                       r_lk_wr;
  logic [3:0]                 r_lk_wstrb;
  logic [31:0]                r_lk_addr;
  logic [31:0]                r_lk_wdata;

  logic        w_full;
  logic        w_empty;
  logic        w_req;
  logic        w_own;
  logic        w_hs;
  logic        w_pop;
  logic        w_head;
  logic        w_wr;
  logic [3:0]  w_wstrb;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
    else return p + PW'(1);
  endfunction

  assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);
  assign w_hs    = w_req & mem_addr_ok;
  assign w_pop   = mem_data_ok & ~w_empty;
  assign w_head  = r_own_q[r_rptr];

  // Owner encoding: 0 = fetch, 1 = data.
  always_comb begin
    w_req       = 1'b0;
    w_own       = r_lk_own;
    w_state_nxt = r_state;
    unique case (r_state)
      ST_ARB: begin
        if (!w_full && (inst_req || data_req)) begin
          w_req = 1'b1;
          w_own = data_req && !(inst_req && (r_starve == SW'(STARVE_LIMIT)));
          if (!mem_addr_ok) w_state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        w_req = 1'b1;
        if (mem_addr_ok) w_state_nxt = ST_ARB;
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // A locked request replays its captured payload even if the requester misbehaves.
  always_comb begin
    w_addr  = inst_addr;
    w_wr    = 1'b0;
    w_wstrb = 4'h0;
    w_wdata = 32'h0;
    if (r_state == ST_LOCK) begin
      w_addr  = r_lk_addr;
      w_wr    = r_lk_wr;
      w_wstrb = r_lk_wstrb;
      w_wdata = r_lk_wdata;
    end else if (w_own) begin
      w_addr  = data_addr;
      w_wr    = data_wr;
      w_wstrb = data_wstrb;
      w_wdata = data_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_ARB;
      r_own_q    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_perr     <= 1'b0;
      r_lk_own   <= 1'b0;
      r_lk_wr    <= 1'b0;
      r_lk_wstrb <= 4'h0;
      r_lk_addr  <= 32'h0;
      r_lk_wdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_ARB && w_req && !mem_addr_ok) begin
        r_lk_own   <= w_own;
        r_lk_wr    <= w_wr;
        r_lk_wstrb <= w_wstrb;
        r_lk_addr  <= w_addr;
        r_lk_wdata <= w_wdata;
      end
      if (w_hs) begin
        r_own_q[r_wptr] <= w_own;
        r_wptr          <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (mem_data_ok && w_empty) r_perr <= 1'b1;
      if ((w_hs && !w_own) || !inst_req) r_starve <= '0;
      else if (w_hs && w_own && (r_starve != SW'(STARVE_LIMIT))) r_starve <= r_starve + SW'(1);
    end
  end

  // Every output is forced low while reset is asserted.
  assign mem_req      = resetn & w_req;
  assign mem_wr       = resetn & w_wr;
  assign mem_wstrb    = resetn ? w_wstrb : 4'h0;
  assign mem_addr     = resetn ? w_addr : 32'h0;
  assign mem_wdata    = resetn ? w_wdata : 32'h0;
  assign inst_addr_ok = resetn & w_hs & ~w_own;
  assign data_addr_ok = resetn & w_hs & w_own;
  assign inst_data_ok = resetn & w_pop & ~w_head;
  assign data_data_ok = resetn & w_pop & w_head;
  assign inst_rdata   = resetn ? mem_rdata : 32'h0;
  assign data_rdata   = resetn ? mem_rdata : 32'h0;
  assign proto_err    = resetn & r_perr;
  assign o_dbg_state  = resetn & (r_state == ST_LOCK);

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed and random bench for sram_like_arbiter against a queue-based reference model.
module tb_sram_like_arbiter;

  localparam int MAXO  = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        proto_err;
  logic        o_dbg_state;

  sram_like_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .proto_err(proto_err), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: outstanding owners in issue order (0 fetch, 1 data)
  bit          m_q[$];
  bit          m_lock = 0;
  bit          m_lk_own = 0;
  logic        m_lk_wr = 0;
  logic [3:0]  m_lk_wstrb = 0;
  logic [31:0] m_lk_addr = 0;
  logic [31:0] m_lk_wdata = 0;
  int          m_starve = 0;
  bit          m_perr = 0;

  // snapshots of the last checked cycle
  bit          x_inst_hs, x_data_hs;
  logic        s_req, s_wr, s_inst_aok, s_data_aok, s_inst_dok, s_data_dok, s_perr, s_dbg;
  logic [31:0] s_addr, s_inst_rdata, s_data_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit          e_req, e_own, e_ia, e_da, e_id, e_dd;
    logic        e_wr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    e_req = 0; e_own = 0; e_wr = 0; e_wstrb = 0; e_addr = 0; e_wdata = 0;
    if (resetn) begin
      if (m_lock) begin
        e_req = 1; e_own = m_lk_own;
        e_addr = m_lk_addr; e_wr = m_lk_wr; e_wstrb = m_lk_wstrb; e_wdata = m_lk_wdata;
      end else if (m_q.size() < MAXO && (inst_req || data_req)) begin
        e_req = 1;
        e_own = !(inst_req && (!data_req || m_starve == LIMIT));
        if (e_own) begin
          e_addr = data_addr; e_wr = data_wr; e_wstrb = data_wstrb; e_wdata = data_wdata;
        end else begin
          e_addr = inst_addr;
        end
      end
    end
    e_ia = e_req && mem_addr_ok && !e_own;
    e_da = e_req && mem_addr_ok && e_own;
    e_id = resetn && mem_data_ok && m_q.size() > 0 && !m_q[0];
    e_dd = resetn && mem_data_ok && m_q.size() > 0 && m_q[0];
    chk("mem_req", mem_req, e_req);
    if (e_req) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wr", mem_wr, e_wr);
      chk("mem_wstrb", mem_wstrb, e_wstrb);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("inst_addr_ok", inst_addr_ok, e_ia);
    chk("data_addr_ok", data_addr_ok, e_da);
    chk("inst_data_ok", inst_data_ok, e_id);
    chk("data_data_ok", data_data_ok, e_dd);
    chk("inst_rdata", inst_rdata, resetn ? mem_rdata : 32'h0);
    chk("data_rdata", data_rdata, resetn ? mem_rdata : 32'h0);
    chk("proto_err", proto_err, resetn && m_perr);
    chk("lock_state", o_dbg_state, resetn && m_lock);
    s_req = mem_req; s_addr = mem_addr; s_wr = mem_wr;
    s_inst_aok = inst_addr_ok; s_data_aok = data_addr_ok;
    s_inst_dok = inst_data_ok; s_data_dok = data_data_ok;
    s_inst_rdata = inst_rdata; s_data_rdata = data_rdata;
    s_perr = proto_err; s_dbg = o_dbg_state;
    x_inst_hs = e_ia; x_data_hs = e_da;
    @(posedge clk);
    if (!resetn) begin
      m_q.delete(); m_lock = 0; m_starve = 0; m_perr = 0;
    end else begin
      if (mem_data_ok) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_perr = 1;
      end
      if (e_req && mem_addr_ok) begin
        m_q.push_back(e_own);
        m_lock = 0;
      end else if (e_req && !m_lock) begin
        m_lock = 1; m_lk_own = e_own;
        m_lk_addr = e_addr; m_lk_wr = e_wr; m_lk_wstrb = e_wstrb; m_lk_wdata = e_wdata;
      end
      if (e_ia || !inst_req) m_starve = 0;
      else if (e_da && m_starve < LIMIT) m_starve++;
    end
    #1;
  endtask

  task automatic drain();
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    for (int i = 0; i < 8 && m_q.size() > 0; i++) begin
      mem_data_ok = 1; mem_rdata = $urandom;
      cycle();
    end
    mem_data_ok = 0;
  endtask

  initial begin
    resetn = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    resetn = 1;

    // single fetch
    inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    cycle();
    chk("fetch_aok", s_inst_aok, 1);
    chk("fetch_addr", s_addr, 32'h1c000000);
    inst_req = 0; mem_addr_ok = 0;
    cycle();
    mem_data_ok = 1; mem_rdata = 32'h02800413;
    cycle();
    chk("fetch_dok", s_inst_dok, 1);
    chk("fetch_rdata", s_inst_rdata, 32'h02800413);
    chk("fetch_no_data_dok", s_data_dok, 0);
    mem_data_ok = 0;

    // contention and starvation guard
    inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_wr = 1; data_wstrb = 4'hf; data_addr = 32'h1c008000; data_wdata = 32'h12345678;
    mem_addr_ok = 1;
    for (int k = 0; k < 5; k++) begin
      mem_data_ok = (m_q.size() > 0);
      cycle();
      if (k < 4) chk("contend_data_grant", s_data_aok, 1);
      else chk("starve_inst_grant", s_inst_aok, 1);
    end
    inst_req = 0; mem_data_ok = 1;
    cycle();
    inst_req = 1; mem_data_ok = 1;
    cycle();
    chk("starve_cleared_data_first", s_data_aok, 1);
    drain();

    // lock stability
    data_req = 1; data_wr = 0; data_wstrb = 0; data_addr = 32'h1c008004; data_wdata = 0;
    inst_addr = 32'h1c000100; mem_addr_ok = 0;
    for (int k = 0; k < 3; k++) begin
      inst_req = (k % 2 == 0);
      cycle();
      chk("lock_addr", s_addr, 32'h1c008004);
      chk("lock_wr", s_wr, 0);
      chk("lock_no_inst", s_inst_aok, 0);
    end
    inst_req = 0; mem_addr_ok = 1;
    cycle();
    chk("lock_done", s_data_aok, 1);
    data_req = 0; mem_addr_ok = 0;
    cycle();
    chk("lock_back_arb", s_dbg, 0);
    drain();

    // full FIFO
    inst_req = 1; mem_addr_ok = 1;
    inst_addr = 32'h1c000200; cycle();
    inst_addr = 32'h1c000204; cycle();
    inst_addr = 32'h1c000208; cycle();
    chk("full_no_req", s_req, 0);
    mem_data_ok = 1; cycle();
    chk("full_pop_no_req", s_req, 0);
    chk("full_pop_dok", s_inst_dok, 1);
    mem_data_ok = 0; cycle();
    chk("full_regrant", s_inst_aok, 1);
    drain();

    // return routing by owner order
    inst_req = 1; inst_addr = 32'h1c000300; mem_addr_ok = 1;
    cycle();
    inst_req = 0; data_req = 1; data_wr = 0; data_addr = 32'h1c008010;
    cycle();
    chk("order_data_aok", s_data_aok, 1);
    data_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'hAAAA0000;
    cycle();
    chk("order_inst_dok", s_inst_dok, 1);
    chk("order_inst_rdata", s_inst_rdata, 32'hAAAA0000);
    mem_rdata = 32'hBBBB0000;
    cycle();
    chk("order_data_dok", s_data_dok, 1);
    chk("order_inst_quiet", s_inst_dok, 0);
    chk("order_data_rdata", s_data_rdata, 32'hBBBB0000);

    // protocol error and reset
    cycle();
    mem_data_ok = 0;
    cycle();
    chk("perr_set", s_perr, 1);
    cycle();
    chk("perr_sticky", s_perr, 1);
    resetn = 0; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    cycle();
    chk("rst_perr", s_perr, 0);
    chk("rst_iaok", s_inst_aok, 0);
    chk("rst_daok", s_data_aok, 0);
    chk("rst_idok", s_inst_dok, 0);
    chk("rst_ddok", s_data_dok, 0);
    resetn = 1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    cycle();
    chk("post_rst_perr", s_perr, 0);

    // random traffic
    x_inst_hs = 0; x_data_hs = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!inst_req || x_inst_hs) begin
        inst_req = $urandom_range(0, 1);
        inst_addr = $urandom & 32'hffff_fffc;
      end
      if (!data_req || x_data_hs) begin
        data_req = $urandom_range(0, 1);
        data_wr = $urandom_range(0, 1);
        data_wstrb = 4'($urandom);
        data_addr = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      resetn = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
